// File: rtl/cdb_pkg.sv
// Shared types and defaults for the common-data-bus broadcaster.
// Tag 0 is reserved as the "no producer" marker seen by the RAT and reservation stations.
package cdb_pkg;

    localparam int CDB_TAG_W  = 4;
    localparam int CDB_DATA_W = 32;

    localparam logic [CDB_TAG_W-1:0] NULL_TAG = '0;

    typedef struct packed {
        logic [CDB_TAG_W-1:0]  tag;
        logic [CDB_DATA_W-1:0] value;
    } cdb_entry_t;

endpackage

// File: rtl/cdb_src_fifo.sv
// Per-source result buffer: DEPTH entries, power-of-two pointers wrap naturally.
// Flush wins over push/pop; storage is not reset because count gates every read.
module cdb_src_fifo
    import cdb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       flush,
    input  logic       push,
    input  logic       pop,
    input  cdb_entry_t din,
    output cdb_entry_t dout,
    output logic       empty,
    output logic       full
);

    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    cdb_entry_t    mem_q [DEPTH];
    logic          push_ok, pop_ok;

    assign empty   = (count_q == '0);
    assign full    = (count_q == (AW+1)'(DEPTH));
    assign push_ok = push && !full && !flush;
    assign pop_ok  = pop && !empty && !flush;
    assign dout    = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + (AW+1)'(1);
                2'b01:   count_d = count_q - (AW+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/cdb_broadcaster.sv
// Common-data-bus transmitter: buffers results per functional unit and broadcasts
// one per cycle using round-robin arbitration starting after the last grant.
module cdb_broadcaster
    import cdb_pkg::*;
#(
    parameter int N_SRC  = 2,
    parameter int DEPTH  = 2,
    parameter int TAG_W  = CDB_TAG_W,
    parameter int DATA_W = CDB_DATA_W,
    localparam int SRC_W = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    flush,
    input  logic [N_SRC-1:0]        src_valid,
    input  logic [N_SRC*TAG_W-1:0]  src_tag,
    input  logic [N_SRC*DATA_W-1:0] src_value,
    output logic [N_SRC-1:0]        src_ready,
    output logic                    broadcast_valid,
    output logic [TAG_W-1:0]        broadcast_tag,
    output logic [DATA_W-1:0]       broadcast_value,
    output logic [SRC_W-1:0]        broadcast_src,
    output logic                    err_null_tag
);

    cdb_entry_t         fifo_din  [N_SRC];
    cdb_entry_t         fifo_dout [N_SRC];
    logic [N_SRC-1:0]   push, pop, empty, full, null_hit, accept;

    logic               grant_vld;
    logic [SRC_W-1:0]   grant_idx;

    logic               bcast_valid_q, bcast_valid_d;
    logic [TAG_W-1:0]   bcast_tag_q, bcast_tag_d;
    logic [DATA_W-1:0]  bcast_value_q, bcast_value_d;
    logic [SRC_W-1:0]   bcast_src_q, bcast_src_d;
    logic [SRC_W-1:0]   last_grant_q, last_grant_d;
    logic               err_q, err_d;

    for (genvar i = 0; i < N_SRC; i++) begin : g_src
        assign fifo_din[i].tag   = CDB_TAG_W'(src_tag[i*TAG_W +: TAG_W]);
        assign fifo_din[i].value = CDB_DATA_W'(src_value[i*DATA_W +: DATA_W]);
        assign null_hit[i]       = (fifo_din[i].tag == NULL_TAG);

        cdb_src_fifo #(.DEPTH(DEPTH)) u_fifo (
            .clk     (clk),
            .reset_n (reset_n),
            .flush   (flush),
            .push    (push[i]),
            .pop     (pop[i]),
            .din     (fifo_din[i]),
            .dout    (fifo_dout[i]),
            .empty   (empty[i]),
            .full    (full[i])
        );
    end

    // Ready comes from registered occupancy only, so a full FIFO popping this cycle stays not-ready.
    assign src_ready = ~full;
    assign accept    = src_valid & src_ready;
    assign push      = accept & ~null_hit & {N_SRC{~flush}};

    always_comb begin
        int idx;
        idx       = 0;
        grant_vld = 1'b0;
        grant_idx = last_grant_q;
        // Walk offsets from farthest to nearest so the nearest non-empty source wins.
        for (int off = N_SRC; off >= 1; off--) begin
            idx = (int'(last_grant_q) + off) % N_SRC;
            if (!empty[idx]) begin
                grant_vld = 1'b1;
                grant_idx = SRC_W'(idx);
            end
        end
    end

    always_comb begin
        pop           = '0;
        bcast_valid_d = 1'b0;
        bcast_tag_d   = '0;
        bcast_value_d = '0;
        bcast_src_d   = bcast_src_q;
        last_grant_d  = last_grant_q;
        err_d         = err_q | (|(accept & null_hit) & !flush);
        if (grant_vld && !flush) begin
            pop[grant_idx] = 1'b1;
            bcast_valid_d  = 1'b1;
            bcast_tag_d    = TAG_W'(fifo_dout[grant_idx].tag);
            bcast_value_d  = DATA_W'(fifo_dout[grant_idx].value);
            bcast_src_d    = grant_idx;
            last_grant_d   = grant_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            bcast_valid_q <= 1'b0;
            bcast_tag_q   <= '0;
            bcast_value_q <= '0;
            bcast_src_q   <= '0;
            last_grant_q  <= SRC_W'(N_SRC - 1);
            err_q         <= 1'b0;
        end else begin
            bcast_valid_q <= bcast_valid_d;
            bcast_tag_q   <= bcast_tag_d;
            bcast_value_q <= bcast_value_d;
            bcast_src_q   <= bcast_src_d;
            last_grant_q  <= last_grant_d;
            err_q         <= err_d;
        end
    end

    assign broadcast_valid = bcast_valid_q;
    assign broadcast_tag   = bcast_tag_q;
    assign broadcast_value = bcast_value_q;
    assign broadcast_src   = bcast_src_q;
    assign err_null_tag    = err_q;

endmodule

// File: tb/tb_cdb_broadcaster.sv
// Bench for cdb_broadcaster: directed scenarios then random traffic, each cycle
// compared against a queue-based model of the buffering and round-robin rules.
module tb_cdb_broadcaster;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        flush;
    logic [1:0]  src_valid;
    logic [7:0]  src_tag;
    logic [63:0] src_value;
    logic [1:0]  src_ready;
    logic        broadcast_valid;
    logic [3:0]  broadcast_tag;
    logic [31:0] broadcast_value;
    logic [0:0]  broadcast_src;
    logic        err_null_tag;

    cdb_broadcaster #(.N_SRC(2), .DEPTH(DEPTH), .TAG_W(4), .DATA_W(32)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .flush           (flush),
        .src_valid       (src_valid),
        .src_tag         (src_tag),
        .src_value       (src_value),
        .src_ready       (src_ready),
        .broadcast_valid (broadcast_valid),
        .broadcast_tag   (broadcast_tag),
        .broadcast_value (broadcast_value),
        .broadcast_src   (broadcast_src),
        .err_null_tag    (err_null_tag)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  tag;
        logic [31:0] val;
    } ent_t;

    ent_t        mq [2][$];
    int          m_lg;
    logic        m_v, m_err;
    logic [3:0]  m_t;
    logic [31:0] m_d;
    logic [0:0]  m_src;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, advance the model by the same edge, then compare.
    task automatic step(input logic rn, input logic fl, input logic [1:0] v,
                        input logic [3:0] t0, input logic [31:0] d0,
                        input logic [3:0] t1, input logic [31:0] d1);
        logic [1:0] rdy;
        logic       found;
        int         g;
        ent_t       e;
        reset_n   = rn;
        flush     = fl;
        src_valid = v;
        src_tag   = {t1, t0};
        src_value = {d1, d0};
        @(posedge clk);
        if (!rn) begin
            mq[0].delete(); mq[1].delete();
            m_err = 1'b0; m_lg = 1;
            m_v = 1'b0; m_t = '0; m_d = '0; m_src = '0;
        end else if (fl) begin
            mq[0].delete(); mq[1].delete();
            m_v = 1'b0; m_t = '0; m_d = '0;
        end else begin
            for (int i = 0; i < 2; i++) rdy[i] = (mq[i].size() != DEPTH);
            found = 1'b0;
            for (int off = 1; off <= 2; off++) begin
                g = (m_lg + off) % 2;
                if (!found && mq[g].size() > 0) begin
                    found = 1'b1;
                    e = mq[g].pop_front();
                    m_v = 1'b1; m_t = e.tag; m_d = e.val;
                    m_lg = g; m_src = 1'(g);
                end
            end
            if (!found) begin
                m_v = 1'b0; m_t = '0; m_d = '0;
            end
            if (v[0] && rdy[0]) begin
                if (t0 == 4'd0) m_err = 1'b1; else mq[0].push_back({t0, d0});
            end
            if (v[1] && rdy[1]) begin
                if (t1 == 4'd0) m_err = 1'b1; else mq[1].push_back({t1, d1});
            end
        end
        #1;
        chk("valid", 64'(broadcast_valid), 64'(m_v));
        chk("tag",   64'(broadcast_tag),   64'(m_t));
        chk("value", 64'(broadcast_value), 64'(m_d));
        chk("src",   64'(broadcast_src),   64'(m_src));
        chk("err",   64'(err_null_tag),    64'(m_err));
        chk("ready", 64'(src_ready),
            64'({mq[1].size() != DEPTH, mq[0].size() != DEPTH}));
    endtask

    initial begin
        reset_n = 1'b0; flush = 1'b0; src_valid = '0; src_tag = '0; src_value = '0;
        m_lg = 1; m_v = 0; m_err = 0; m_t = 0; m_d = 0; m_src = 0;

        // reset, then a single add result
        step(0, 0, 2'b00, 0, 0, 0, 0);
        step(0, 0, 2'b00, 0, 0, 0, 0);
        step(1, 0, 2'b00, 0, 0, 0, 0);
        step(1, 0, 2'b01, 4'd3, 32'h10, 0, 0);
        step(1, 0, 2'b00, 0, 0, 0, 0);
        step(1, 0, 2'b00, 0, 0, 0, 0);

        // contention, then both backlogged
        step(1, 0, 2'b11, 4'd1, 32'hA, 4'd9, 32'hB);
        step(1, 0, 2'b00, 0, 0, 0, 0);
        step(1, 0, 2'b00, 0, 0, 0, 0);
        for (int k = 0; k < 8; k++)
            step(1, 0, 2'b11, 4'(k + 1), 32'(100 + k), 4'(k + 8), 32'(200 + k));
        for (int k = 0; k < 6; k++) step(1, 0, 2'b00, 0, 0, 0, 0);

        // source 1 held valid so its FIFO fills while sharing the bus
        for (int k = 0; k < 8; k++)
            step(1, 0, 2'b11, 4'd2, 32'(300 + k), 4'd7, 32'(400 + k));
        for (int k = 0; k < 6; k++) step(1, 0, 2'b00, 0, 0, 0, 0);

        // null tag, then a normal tag on the same source
        step(1, 0, 2'b10, 0, 0, 4'd0, 32'h55);
        step(1, 0, 2'b00, 0, 0, 0, 0);
        step(1, 0, 2'b10, 0, 0, 4'd5, 32'h66);
        step(1, 0, 2'b00, 0, 0, 0, 0);
        step(1, 0, 2'b00, 0, 0, 0, 0);

        // flush mid-stream with concurrent pushes
        step(1, 0, 2'b11, 4'd4, 32'h40, 4'd6, 32'h60);
        step(1, 0, 2'b11, 4'd5, 32'h50, 4'd7, 32'h70);
        step(1, 1, 2'b11, 4'd8, 32'h80, 4'd0, 32'h90);
        for (int k = 0; k < 4; k++) step(1, 0, 2'b00, 0, 0, 0, 0);

        // reset with a broadcast in flight, then contention after release
        step(1, 0, 2'b11, 4'd3, 32'h33, 4'd4, 32'h44);
        step(1, 0, 2'b11, 4'd5, 32'h55, 4'd6, 32'h66);
        step(0, 0, 2'b11, 4'd7, 32'h77, 4'd8, 32'h88);
        step(1, 0, 2'b11, 4'd9, 32'h99, 4'd10, 32'hAA);
        step(1, 0, 2'b00, 0, 0, 0, 0);
        step(1, 0, 2'b00, 0, 0, 0, 0);

        // random traffic with occasional flush and reset
        for (int k = 0; k < 400; k++) begin
            step(($urandom_range(0, 63) != 0), ($urandom_range(0, 31) == 0),
                 2'($urandom),
                 4'($urandom_range(0, 15)), $urandom,
                 4'($urandom_range(0, 15)), $urandom);
        end
        for (int k = 0; k < 4; k++) step(1, 0, 2'b00, 0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
